// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths and the bit-reversal helper used by
// the load path, the butterfly and the twiddle blocks.
package fft_pkg;

    localparam int unsigned FFT_DATA_WIDTH     = 16;
    localparam int unsigned FFT_ADDR_WIDTH     = 5;
    localparam int unsigned FFT_MAX_ADDR_WIDTH = 16;

    // Reverse the low 'width' bits of 'a'; bits above 'width' come back as 0.
    function automatic logic [FFT_MAX_ADDR_WIDTH-1:0] bitrev(
        input logic [FFT_MAX_ADDR_WIDTH-1:0] a,
        input int unsigned                   width
    );
        logic [FFT_MAX_ADDR_WIDTH-1:0] r;
        logic [3:0]                    idx;
        r = '0;
        for (int unsigned i = 0; i < FFT_MAX_ADDR_WIDTH; i++) begin
            if (i < width) begin
                idx  = 4'(width - 1 - i);
                r[i] = a[idx];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// One N x DATA_WIDTH bank: true dual-port, synchronous write, registered
// one-cycle read returning old data on read-during-write, port A wins when
// both ports write the same address. The array itself is never reset.
module fft_bank_ram
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = FFT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array writes; port A is applied last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (en_b && we_b) begin
            mem[addr_b] <= din_b;
        end
        if (en_a && we_a) begin
            mem[addr_a] <= din_a;
        end
    end

    // Registered reads sample the pre-write contents; outputs hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            if (en_a && !we_a) begin
                dout_a <= mem[addr_a];
            end
            if (en_b && !we_b) begin
                dout_b <= mem[addr_b];
            end
        end
    end

endmodule

// File: rtl/fft_pingpong_ram.sv
// Ping-pong sample memory: one bank streams in a frame while the other is
// processed in place by the compute side; a swap handshake exchanges them.
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = FFT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = FFT_ADDR_WIDTH,
    parameter bit          BIT_REVERSE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    input  logic                  cp_we_a,
    input  logic                  cp_we_b,
    input  logic                  cp_en_a,
    input  logic                  cp_en_b,
    input  logic [ADDR_WIDTH-1:0] cp_addr_a,
    input  logic [ADDR_WIDTH-1:0] cp_addr_b,
    input  logic [DATA_WIDTH-1:0] cp_din_a,
    input  logic [DATA_WIDTH-1:0] cp_din_b,
    output logic [DATA_WIDTH-1:0] cp_dout_a,
    output logic [DATA_WIDTH-1:0] cp_dout_b,
    output logic                  cp_dvalid_a,
    output logic                  cp_dvalid_b,
    output logic                  cp_start,
    output logic                  cp_busy,
    input  logic                  cp_done,
    output logic                  ld_bank
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    logic [ADDR_WIDTH-1:0] ld_cnt;
    logic                  ld_full;
    logic                  ld_accept;
    logic                  swap;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [FFT_MAX_ADDR_WIDTH-1:0] ld_cnt_ext;
    logic [FFT_MAX_ADDR_WIDTH-1:0] ld_cnt_rev;

    // Bank of the most recent read per port, so dout holds across a swap.
    logic rd_sel_a;
    logic rd_sel_b;

    logic                  bk_en_a   [2];
    logic                  bk_we_a   [2];
    logic [ADDR_WIDTH-1:0] bk_addr_a [2];
    logic [DATA_WIDTH-1:0] bk_din_a  [2];
    logic [DATA_WIDTH-1:0] bk_dout_a [2];
    logic                  bk_en_b   [2];
    logic                  bk_we_b   [2];
    logic [ADDR_WIDTH-1:0] bk_addr_b [2];
    logic [DATA_WIDTH-1:0] bk_din_b  [2];
    logic [DATA_WIDTH-1:0] bk_dout_b [2];

    assign ld_ready   = !ld_full;
    assign ld_accept  = ld_valid && !ld_full;
    // Swap uses registered cp_busy, so it can never share an edge with cp_done.
    assign swap       = ld_full && !cp_busy;
    assign ld_cnt_ext = FFT_MAX_ADDR_WIDTH'(ld_cnt);
    assign ld_cnt_rev = bitrev(ld_cnt_ext, ADDR_WIDTH);
    assign ld_addr    = BIT_REVERSE ? ld_cnt_rev[ADDR_WIDTH-1:0] : ld_cnt;

    // Frame fill count, swap handshake and compute-side status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt   <= '0;
            ld_full  <= 1'b0;
            ld_bank  <= 1'b0;
            cp_busy  <= 1'b0;
            cp_start <= 1'b0;
        end else begin
            cp_start <= swap;
            if (ld_accept) begin
                ld_cnt <= ld_cnt + 1'b1;
            end
            if (swap) begin
                ld_full <= 1'b0;
                ld_bank <= !ld_bank;
                cp_busy <= 1'b1;
            end else begin
                if (ld_accept && (ld_cnt == LAST_ADDR)) begin
                    ld_full <= 1'b1;
                end
                if (cp_done && cp_busy) begin
                    cp_busy <= 1'b0;
                end
            end
        end
    end

    // Read-valid flags and read-bank tracking; accesses are dropped while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cp_dvalid_a <= 1'b0;
            cp_dvalid_b <= 1'b0;
            rd_sel_a    <= 1'b0;
            rd_sel_b    <= 1'b0;
        end else begin
            cp_dvalid_a <= cp_busy && cp_en_a && !cp_we_a;
            cp_dvalid_b <= cp_busy && cp_en_b && !cp_we_b;
            if (cp_busy && cp_en_a && !cp_we_a) begin
                rd_sel_a <= !ld_bank;
            end
            if (cp_busy && cp_en_b && !cp_we_b) begin
                rd_sel_b <= !ld_bank;
            end
        end
    end

    // Route the load path to the load bank's port A and compute ports to the other bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            if (1'(b) == ld_bank) begin
                bk_en_a[b]   = ld_accept;
                bk_we_a[b]   = 1'b1;
                bk_addr_a[b] = ld_addr;
                bk_din_a[b]  = ld_data;
                bk_en_b[b]   = 1'b0;
                bk_we_b[b]   = 1'b0;
                bk_addr_b[b] = '0;
                bk_din_b[b]  = '0;
            end else begin
                bk_en_a[b]   = cp_busy && cp_en_a;
                bk_we_a[b]   = cp_we_a;
                bk_addr_a[b] = cp_addr_a;
                bk_din_a[b]  = cp_din_a;
                bk_en_b[b]   = cp_busy && cp_en_b;
                bk_we_b[b]   = cp_we_b;
                bk_addr_b[b] = cp_addr_b;
                bk_din_b[b]  = cp_din_b;
            end
        end
    end

    assign cp_dout_a = bk_dout_a[rd_sel_a];
    assign cp_dout_b = bk_dout_b[rd_sel_b];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_a   (bk_en_a[g]),
            .we_a   (bk_we_a[g]),
            .addr_a (bk_addr_a[g]),
            .din_a  (bk_din_a[g]),
            .dout_a (bk_dout_a[g]),
            .en_b   (bk_en_b[g]),
            .we_b   (bk_we_b[g]),
            .addr_b (bk_addr_b[g]),
            .din_b  (bk_din_b[g]),
            .dout_b (bk_dout_b[g])
        );
    end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Directed bench: two instances (bit-reversed and natural load order) share
// all stimulus; expected values are hand-derived constants.
module tb_fft_pingpong_ram;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          cp_we_a = 1'b0, cp_we_b = 1'b0;
    logic          cp_en_a = 1'b0, cp_en_b = 1'b0;
    logic [AW-1:0] cp_addr_a = '0, cp_addr_b = '0;
    logic [DW-1:0] cp_din_a = '0, cp_din_b = '0;
    logic          cp_done = 1'b0;

    logic          r_ready, r_start, r_busy, r_bank, r_dva, r_dvb;
    logic [DW-1:0] r_douta, r_doutb;
    logic          n_ready, n_start, n_busy, n_bank, n_dva, n_dvb;
    logic [DW-1:0] n_douta, n_doutb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fft_pingpong_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIT_REVERSE(1'b1)) u_rev (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(r_ready),
        .cp_we_a(cp_we_a), .cp_we_b(cp_we_b), .cp_en_a(cp_en_a), .cp_en_b(cp_en_b),
        .cp_addr_a(cp_addr_a), .cp_addr_b(cp_addr_b), .cp_din_a(cp_din_a), .cp_din_b(cp_din_b),
        .cp_dout_a(r_douta), .cp_dout_b(r_doutb), .cp_dvalid_a(r_dva), .cp_dvalid_b(r_dvb),
        .cp_start(r_start), .cp_busy(r_busy), .cp_done(cp_done), .ld_bank(r_bank)
    );

    fft_pingpong_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIT_REVERSE(1'b0)) u_nat (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(n_ready),
        .cp_we_a(cp_we_a), .cp_we_b(cp_we_b), .cp_en_a(cp_en_a), .cp_en_b(cp_en_b),
        .cp_addr_a(cp_addr_a), .cp_addr_b(cp_addr_b), .cp_din_a(cp_din_a), .cp_din_b(cp_din_b),
        .cp_dout_a(n_douta), .cp_dout_b(n_doutb), .cp_dvalid_a(n_dva), .cp_dvalid_b(n_dvb),
        .cp_start(n_start), .cp_busy(n_busy), .cp_done(cp_done), .ld_bank(n_bank)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status of both instances packed as {ready, start, busy, bank}.
    task automatic check_status(input string tag, input logic [3:0] exp);
        check({tag, "_rev"}, {28'd0, r_ready, r_start, r_busy, r_bank}, {28'd0, exp});
        check({tag, "_nat"}, {28'd0, n_ready, n_start, n_busy, n_bank}, {28'd0, exp});
    endtask

    task automatic load_frame(input int base, input int n);
        ld_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            ld_data = DW'(base + i);
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic cp_idle();
        cp_en_a = 1'b0; cp_en_b = 1'b0; cp_we_a = 1'b0; cp_we_b = 1'b0;
    endtask

    task automatic read2(input logic [AW-1:0] aa, input logic [AW-1:0] ab);
        cp_en_a = 1'b1; cp_we_a = 1'b0; cp_addr_a = aa;
        cp_en_b = 1'b1; cp_we_b = 1'b0; cp_addr_b = ab;
        tick();
        cp_idle();
    endtask

    initial begin
        // Reset values
        #12;
        check_status("rst_status", 4'b1000);
        check("rst_dout_a", {16'd0, r_douta}, 32'd0);
        check("rst_dvalid", {30'd0, r_dva, n_dvb}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Frame 1 (0..31) with ld_valid held high, compute side idle
        load_frame(0, 32);
        check_status("full_no_start", 4'b0000);
        tick();
        check_status("swap_start", 4'b1111);
        tick();
        check_status("start_one_cycle", 4'b1011);

        // Compute reads: bit-reversed vs natural placement
        read2(5'd1, 5'd3);
        check("rev_a1", {16'd0, r_douta}, 32'd16);
        check("rev_b3", {16'd0, r_doutb}, 32'd24);
        read2(5'd5, 5'd6);
        check("nat_a5", {16'd0, n_douta}, 32'd5);
        check("nat_b6", {16'd0, n_doutb}, 32'd6);
        check("nat_dvalid", {30'd0, n_dva, n_dvb}, 32'd3);
        check("rev_a5", {16'd0, r_douta}, 32'd20);
        check("rev_b6", {16'd0, r_doutb}, 32'd12);
        tick();
        check("dvalid_idle", {30'd0, r_dva, r_dvb}, 32'd0);
        check("dout_held", {16'd0, n_douta}, 32'd5);

        // Write collision on addr 7: port A wins
        cp_en_a = 1'b1; cp_we_a = 1'b1; cp_addr_a = 5'd7; cp_din_a = 16'hAAAA;
        cp_en_b = 1'b1; cp_we_b = 1'b1; cp_addr_b = 5'd7; cp_din_b = 16'h5555;
        tick();
        cp_idle();
        check("write_no_dvalid", {30'd0, r_dva, r_dvb}, 32'd0);
        read2(5'd7, 5'd7);
        check("coll_rev", {16'd0, r_douta}, 32'h0000_AAAA);
        check("coll_nat", {16'd0, n_doutb}, 32'h0000_AAAA);

        // Read A while B writes the same address: old data first
        cp_en_a = 1'b1; cp_we_a = 1'b0; cp_addr_a = 5'd2;
        cp_en_b = 1'b1; cp_we_b = 1'b1; cp_addr_b = 5'd2; cp_din_b = 16'h1234;
        tick();
        cp_idle();
        check("rdw_old_rev", {16'd0, r_douta}, 32'd8);
        check("rdw_old_nat", {16'd0, n_douta}, 32'd2);
        read2(5'd2, 5'd0);
        check("rdw_new_rev", {16'd0, r_douta}, 32'h0000_1234);
        check("rdw_new_nat", {16'd0, n_douta}, 32'h0000_1234);

        // Frame 2 while compute busy: back-pressure until release
        load_frame(100, 32);
        check_status("bp_full", 4'b0011);
        tick(); tick(); tick();
        check_status("bp_hold", 4'b0011);
        cp_done = 1'b1;
        tick();
        cp_done = 1'b0;
        check_status("release", 4'b0001);
        tick();
        check_status("bp_swap", 4'b1110);
        tick();
        read2(5'd1, 5'd7);
        check("f2_rev_a1", {16'd0, r_douta}, 32'd116);
        check("f2_nat_a1", {16'd0, n_douta}, 32'd101);
        check("f2_nat_b7", {16'd0, n_doutb}, 32'd107);

        // Release, then compute traffic and cp_done while idle are dropped
        cp_done = 1'b1;
        tick();
        cp_done = 1'b0;
        check_status("release2", 4'b1000);
        cp_en_a = 1'b1; cp_we_a = 1'b1; cp_addr_a = 5'd0; cp_din_a = 16'hDEAD;
        cp_en_b = 1'b1; cp_we_b = 1'b0; cp_addr_b = 5'd3;
        tick();
        cp_idle();
        check("idle_dvalid", {30'd0, r_dva, n_dvb}, 32'd0);
        check("idle_dout_held", {16'd0, n_doutb}, 32'd107);
        cp_done = 1'b1;
        tick();
        cp_done = 1'b0;
        check_status("idle_done", 4'b1000);

        // Frame 3, read back, then reset in the middle of frame 4
        load_frame(300, 32);
        tick();
        check_status("f3_swap", 4'b1111);
        read2(5'd1, 5'd0);
        check("f3_rev_a1", {16'd0, r_douta}, 32'd316);
        check("f3_nat_a1", {16'd0, n_douta}, 32'd301);
        load_frame(200, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_status("mid_rst_status", 4'b1000);
        check("mid_rst_dout", {r_douta, n_douta}, 32'd0);
        check("mid_rst_dvalid", {30'd0, r_dva, n_dva}, 32'd0);
        #3;
        rst_n = 1'b1;
        tick();

        // After reset a full 32-sample frame is needed before cp_start
        load_frame(400, 31);
        check_status("partial_31", 4'b1000);
        tick(); tick();
        check_status("partial_wait", 4'b1000);
        load_frame(431, 1);
        check_status("rst_frame_full", 4'b0000);
        tick();
        check_status("rst_frame_start", 4'b1111);
        read2(5'd31, 5'd16);
        check("rst_nat_a31", {16'd0, n_douta}, 32'd431);
        check("rst_rev_b16", {16'd0, r_doutb}, 32'd401);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
